// File: rtl/proc_run_pkg.sv
// Shared state and termination-cause encodings for the processor run controller.
package proc_run_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_HOLD = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  typedef enum logic [2:0] {
    STAT_NONE    = 3'd0,
    STAT_HALT    = 3'd1,
    STAT_LOOP    = 3'd2,
    STAT_RANGE   = 3'd3,
    STAT_TIMEOUT = 3'd4
  } status_e;

endpackage

// File: rtl/pc_loop_detect.sv
// Branch-to-self detector: counts consecutive RUN cycles with an unchanged fetch address.
module pc_loop_detect #(
  parameter int LOOP_LIMIT = 4
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [31:0] iaddr_i,
  output logic        loop_hit_o
);

  localparam int SW = $clog2(LOOP_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(LOOP_LIMIT);

  logic [31:0]   prev_q, prev_d;
  logic [SW-1:0] same_q, same_d;
  logic          valid_q, valid_d;
  logic [SW-1:0] same_cur;

  // same_cur is the run length including the address presented this cycle.
  always_comb begin
    same_cur = SW'(1);
    if (valid_q && (iaddr_i == prev_q)) begin
      same_cur = (same_q == LIMIT) ? LIMIT : same_q + SW'(1);
    end

    prev_d  = prev_q;
    same_d  = same_q;
    valid_d = valid_q;
    if (clear_i) begin
      prev_d  = '0;
      same_d  = SW'(1);
      valid_d = 1'b0;
    end else if (en_i) begin
      prev_d  = iaddr_i;
      same_d  = same_cur;
      valid_d = 1'b1;
    end
  end

  assign loop_hit_o = en_i && (same_cur == LIMIT);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      prev_q  <= '0;
      same_q  <= SW'(1);
      valid_q <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      same_q  <= same_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/proc_run_monitor.sv
// Run controller for the single-cycle processor: sequences its reset, watches fetch/store
// buses and stops the run on halt word, self-loop, out-of-range fetch or watchdog timeout.
module proc_run_monitor
  import proc_run_pkg::*;
#(
  parameter int          RESET_CYCLES = 1,
  parameter int          MAX_CYCLES   = 100000,
  parameter int          CNT_W        = 32,
  parameter int          LOOP_LIMIT   = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
  parameter int          IMEM_BYTES   = 4096
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [31:0]      iaddr_i,
  input  logic [31:0]      instr_i,
  input  logic             write_enable_to_mem_i,
  input  logic [31:0]      addr_to_mem_i,
  input  logic [31:0]      data_to_mem_i,
  output logic             proc_reset_o,
  output logic             running_o,
  output logic             done_o,
  output logic [2:0]       status_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic [CNT_W-1:0] store_count_o,
  output logic [31:0]      last_store_addr_o,
  output logic [31:0]      last_store_data_o
);

  localparam int              HW         = $clog2(RESET_CYCLES) + 1;
  localparam logic [HW-1:0]   HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_AT = CNT_W'(MAX_CYCLES - 1);

  state_t           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  status_e          status_q, status_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] stc_q, stc_d;
  logic [31:0]      la_q, la_d;
  logic [31:0]      ld_q, ld_d;

  logic in_run;
  logic loop_hit;
  logic halt_hit;
  logic range_hit;
  logic tmo_hit;

  assign in_run    = (state_q == ST_RUN);
  assign halt_hit  = (instr_i == HALT_WORD);
  assign range_hit = (iaddr_i >= 32'(IMEM_BYTES));
  assign tmo_hit   = (cyc_q == TIMEOUT_AT);

  pc_loop_detect #(
    .LOOP_LIMIT(LOOP_LIMIT)
  ) u_loop (
    .clock_i   (clock_i),
    .reset_i   (reset_i),
    .clear_i   (!in_run),
    .en_i      (in_run),
    .iaddr_i   (iaddr_i),
    .loop_hit_o(loop_hit)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    status_d = status_q;
    cyc_d    = cyc_q;
    stc_d    = stc_q;
    la_d     = la_q;
    ld_d     = ld_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d  = ST_HOLD;
          hold_d   = '0;
          status_d = STAT_NONE;
          cyc_d    = '0;
          stc_d    = '0;
          la_d     = '0;
          ld_d     = '0;
        end
      end
      ST_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CNT_W'(1);
        // Stores on the terminating cycle still count and are captured.
        if (write_enable_to_mem_i) begin
          if (stc_q != '1) stc_d = stc_q + CNT_W'(1);
          la_d = addr_to_mem_i;
          ld_d = data_to_mem_i;
        end
        if (halt_hit) begin
          state_d  = ST_DONE;
          status_d = STAT_HALT;
        end else if (loop_hit) begin
          state_d  = ST_DONE;
          status_d = STAT_LOOP;
        end else if (range_hit) begin
          state_d  = ST_DONE;
          status_d = STAT_RANGE;
        end else if (tmo_hit) begin
          state_d  = ST_DONE;
          status_d = STAT_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      status_q <= STAT_NONE;
      cyc_q    <= '0;
      stc_q    <= '0;
      la_q     <= '0;
      ld_q     <= '0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      status_q <= status_d;
      cyc_q    <= cyc_d;
      stc_q    <= stc_d;
      la_q     <= la_d;
      ld_q     <= ld_d;
    end
  end

  assign proc_reset_o      = !in_run;
  assign running_o         = in_run;
  assign done_o            = (state_q == ST_DONE);
  assign status_o          = status_q;
  assign cycle_count_o     = cyc_q;
  assign store_count_o     = stc_q;
  assign last_store_addr_o = la_q;
  assign last_store_data_o = ld_q;

endmodule

// File: tb/tb_proc_run_monitor.sv
// Directed cycle-table and hand-sequence bench for proc_run_monitor (MAX_CYCLES=10, LOOP_LIMIT=4).
module tb_proc_run_monitor;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clock = 1'b0;
  logic        reset, start, we;
  logic [31:0] iaddr, instr, addr, data;
  logic        proc_reset, running, done;
  logic [2:0]  status;
  logic [31:0] cyc, stc, la, ld;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  proc_run_monitor #(
    .RESET_CYCLES(1),
    .MAX_CYCLES  (10),
    .CNT_W       (32),
    .LOOP_LIMIT  (4),
    .HALT_WORD   (32'hFFFF_FFFF),
    .IMEM_BYTES  (4096)
  ) dut (
    .clock_i              (clock),
    .reset_i              (reset),
    .start_i              (start),
    .iaddr_i              (iaddr),
    .instr_i              (instr),
    .write_enable_to_mem_i(we),
    .addr_to_mem_i        (addr),
    .data_to_mem_i        (data),
    .proc_reset_o         (proc_reset),
    .running_o            (running),
    .done_o               (done),
    .status_o             (status),
    .cycle_count_o        (cyc),
    .store_count_o        (stc),
    .last_store_addr_o    (la),
    .last_store_data_o    (ld)
  );

  typedef struct packed {
    logic        pr;
    logic        run;
    logic        dn;
    logic [2:0]  st;
    logic [31:0] cyc;
    logic [31:0] stc;
    logic [31:0] la;
    logic [31:0] ld;
  } obs_t;

  typedef struct {
    logic        rst_n;
    logic        start;
    logic [31:0] iaddr;
    logic [31:0] instr;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    obs_t        exp;
  } vec_t;

  function automatic obs_t mko(input logic pr, input logic run, input logic dn, input logic [2:0] st,
                               input logic [31:0] c, input logic [31:0] s,
                               input logic [31:0] a, input logic [31:0] d);
    obs_t o;
    o.pr = pr; o.run = run; o.dn = dn; o.st = st;
    o.cyc = c; o.stc = s; o.la = a; o.ld = d;
    return o;
  endfunction

  function automatic vec_t mkv(input logic r, input logic s, input logic [31:0] ia, input logic [31:0] ins,
                               input logic w, input logic [31:0] a, input logic [31:0] d, input obs_t e);
    vec_t v;
    v.rst_n = r; v.start = s; v.iaddr = ia; v.instr = ins;
    v.we = w; v.addr = a; v.data = d; v.exp = e;
    return v;
  endfunction

  // Present inputs for one cycle, then settle just after the sampling edge.
  task automatic drive(input logic r, input logic s, input logic [31:0] ia, input logic [31:0] ins,
                       input logic w, input logic [31:0] a, input logic [31:0] d);
    reset = r; start = s; iaddr = ia; instr = ins; we = w; addr = a; data = d;
    @(posedge clock);
    #1;
  endtask

  task automatic run_cycle(input logic [31:0] ia, input logic [31:0] ins);
    drive(1'b1, 1'b0, ia, ins, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic start_run();
    drive(1'b1, 1'b1, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check(input string name, input obs_t exp);
    obs_t got;
    got = {proc_reset, running, done, status, cyc, stc, la, ld};
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("[%0t] %s ok: pr=%0b run=%0b done=%0b st=%0d cyc=%0d stores=%0d last=%h/%h",
               $time, name, got.pr, got.run, got.dn, got.st, got.cyc, got.stc, got.la, got.ld);
    end else begin
      $display("FAIL %s: got pr=%0b run=%0b done=%0b st=%0d cyc=%0d stores=%0d last=%h/%h ; want pr=%0b run=%0b done=%0b st=%0d cyc=%0d stores=%0d last=%h/%h",
               name, got.pr, got.run, got.dn, got.st, got.cyc, got.stc, got.la, got.ld,
               exp.pr, exp.run, exp.dn, exp.st, exp.cyc, exp.stc, exp.la, exp.ld);
    end
  endtask

  vec_t tbl[13];

  initial begin
    obs_t idle0, halted;
    idle0  = mko(1, 0, 0, 0, 0, 0, 0, 0);
    halted = mko(1, 0, 1, 1, 5, 3, 32'h108, 32'hCC);

    // Reset, start-to-run latency, stores, ignored start in RUN, halt and frozen DONE.
    tbl[0]  = mkv(0, 0, 32'h0,  NOP,  0, 32'h0,   32'h0,  idle0);
    tbl[1]  = mkv(0, 1, 32'h0,  NOP,  1, 32'h500, 32'h11, idle0);
    tbl[2]  = mkv(0, 0, 32'h0,  NOP,  0, 32'h0,   32'h0,  idle0);
    tbl[3]  = mkv(1, 0, 32'h0,  NOP,  0, 32'h0,   32'h0,  idle0);
    tbl[4]  = mkv(1, 1, 32'h0,  NOP,  1, 32'h300, 32'hEE, idle0);
    tbl[5]  = mkv(1, 0, 32'h0,  NOP,  1, 32'h300, 32'hEE, mko(0, 1, 0, 0, 0, 0, 0, 0));
    tbl[6]  = mkv(1, 0, 32'h0,  NOP,  1, 32'h100, 32'hAA, mko(0, 1, 0, 0, 1, 1, 32'h100, 32'hAA));
    tbl[7]  = mkv(1, 0, 32'h4,  NOP,  0, 32'h0,   32'h0,  mko(0, 1, 0, 0, 2, 1, 32'h100, 32'hAA));
    tbl[8]  = mkv(1, 0, 32'h8,  NOP,  1, 32'h104, 32'hBB, mko(0, 1, 0, 0, 3, 2, 32'h104, 32'hBB));
    tbl[9]  = mkv(1, 1, 32'hC,  NOP,  0, 32'h0,   32'h0,  mko(0, 1, 0, 0, 4, 2, 32'h104, 32'hBB));
    tbl[10] = mkv(1, 0, 32'h10, HALT, 1, 32'h108, 32'hCC, halted);
    tbl[11] = mkv(1, 0, 32'h10, HALT, 1, 32'h200, 32'hDD, halted);
    tbl[12] = mkv(1, 0, 32'h10, HALT, 1, 32'h200, 32'hDD, halted);

    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].rst_n, tbl[i].start, tbl[i].iaddr, tbl[i].instr, tbl[i].we, tbl[i].addr, tbl[i].data);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // start in DONE clears the previous run's results.
    drive(1'b1, 1'b1, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    check("restart_hold", mko(1, 0, 0, 0, 0, 0, 0, 0));
    drive(1'b1, 1'b0, 32'h0, NOP, 1'b0, 32'h0, 32'h0);
    check("restart_run", mko(0, 1, 0, 0, 0, 0, 0, 0));

    // Self-loop: 0x40 from cycle 3 trips on cycle 6.
    run_cycle(32'h0, NOP);
    run_cycle(32'h4, NOP);
    for (int i = 0; i < 3; i++) run_cycle(32'h40, NOP);
    check("loop_not_early", mko(0, 1, 0, 0, 5, 0, 0, 0));
    run_cycle(32'h40, NOP);
    check("loop_hit", mko(1, 0, 1, 2, 6, 0, 0, 0));

    // Watchdog with MAX_CYCLES=10.
    start_run();
    for (int i = 0; i < 9; i++) run_cycle(32'(4 * i), NOP);
    check("timeout_not_early", mko(0, 1, 0, 0, 9, 0, 0, 0));
    run_cycle(32'd36, NOP);
    check("timeout", mko(1, 0, 1, 4, 10, 0, 0, 0));

    // Halt outranks out-of-range on the same cycle.
    start_run();
    run_cycle(32'h2000, HALT);
    check("halt_over_range", mko(1, 0, 1, 1, 1, 0, 0, 0));

    // Range boundary: 4095 is in range, 4096 is not.
    start_run();
    run_cycle(32'd4095, NOP);
    check("range_edge_in", mko(0, 1, 0, 0, 1, 0, 0, 0));
    run_cycle(32'd4096, NOP);
    check("range_hit", mko(1, 0, 1, 3, 2, 0, 0, 0));

    // Reset in the middle of a run returns to IDLE on the next edge.
    start_run();
    run_cycle(32'h0, NOP);
    drive(1'b1, 1'b0, 32'h4, NOP, 1'b1, 32'h10, 32'h55);
    check("mid_run", mko(0, 1, 0, 0, 2, 1, 32'h10, 32'h55));
    drive(1'b0, 1'b0, 32'h8, NOP, 1'b0, 32'h0, 32'h0);
    check("mid_run_reset", mko(1, 0, 0, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
